// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline stall/flush sequencer for load-use, branches, mul/div and memory wait
module pipe_sequencer #(
  parameter int CNT_W = 32,
  parameter int MDV_MAX = 64,
  parameter int TMO_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcsrcE,
  input  logic             resultsrcE0,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             mdv_opE,
  input  logic             mdv_done,
  input  logic             dmem_reqM,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             mdv_go,
  output logic             mdv_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {RUN, MDV_WAIT} state_t;
  state_t state, nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic done_q;
  logic memwait, lwst, done, tmo_hit, wait_act;
  assign memwait = dmem_reqM & ~dmem_ready;
  assign lwst = resultsrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign done = mdv_done | done_q;
  assign tmo_hit = tmo_cnt == TMO_W'(MDV_MAX - 1);
  assign wait_act = (state == MDV_WAIT) & ~memwait;
  assign busy = state == MDV_WAIT;
  always_comb begin
    {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mdv_go} = '0;
    nxt = state;
    if (reset) begin
      {flushD, flushE} = 2'b11;
      nxt = RUN;
    end else if (memwait) begin
      {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
    end else if (state == RUN) begin
      if (mdv_opE) begin
        {mdv_go, stallF, stallD, stallE, flushM} = 5'b11111;
        nxt = MDV_WAIT;
      end else if (pcsrcE) begin
        {flushD, flushE} = 2'b11;
      end else if (lwst) begin
        {stallF, stallD, flushE} = 3'b111;
      end
    end else if (done) begin
      nxt = RUN;
    end else if (tmo_hit) begin
      flushE = 1'b1;
      nxt = RUN;
    end else begin
      {stallF, stallD, stallE, flushM} = 4'b1111;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      stall_cnt <= '0;
      tmo_cnt <= '0;
      done_q <= 1'b0;
      mdv_err <= 1'b0;
    end else begin
      state <= nxt;
      stall_cnt <= stall_cnt + CNT_W'(stallF);
      done_q <= memwait ? (done_q | mdv_done) : (wait_act & done) ? 1'b0 : done_q;
      tmo_cnt <= mdv_go ? '0 : (wait_act & ~done & ~tmo_hit) ? tmo_cnt + 1'b1 : tmo_cnt;
      mdv_err <= mdv_err | (wait_act & ~done & tmo_hit);
    end
  end
endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline (F, D, E, M, W). It produces the per-stage stall and flush enables from three sources: load-use hazards, taken branches/jumps resolved in E, and two multi-cycle resources. The resources are the iterative mul/div unit, handshaked from E, and the data memory ready line, sampled in M. Operand forwarding stays in the hazard/forwarding logic; this block only sequences pipeline advance.

Parameters:
CNT_W, 32, width of stall-cycle performance counter
MDV_MAX, 64, max cycles allowed in MDV_WAIT before timeout abort
TMO_W, 7, width of MDV timeout counter (must hold MDV_MAX)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
pcsrcE  in  1  taken branch/jump resolved in E
resultsrcE0  in  1  instruction in E is a load
RdE  in  5  destination register of E
Rs1D  in  5  source 1 of D
Rs2D  in  5  source 2 of D
mdv_opE  in  1  E holds a mul/div op (level, stays while E stalled)
mdv_done  in  1  mul/div result valid (1-cycle pulse)
dmem_reqM  in  1  M performs a load/store
dmem_ready  in  1  data memory completes access this cycle
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
stallE  out  1  hold ID/EX
stallM  out  1  hold EX/MEM
flushD  out  1  clear IF/ID
flushE  out  1  clear ID/EX
flushM  out  1  insert bubble into EX/MEM
flushW  out  1  insert bubble into MEM/WB
mdv_go  out  1  start pulse to mul/div unit
mdv_err  out  1  sticky timeout flag
busy  out  1  FSM not in RUN
stall_cnt  out  CNT_W  cycles with stallF=1

Behaviour:
- FSM states: RUN, MDV_WAIT. Mem-wait is a combinational override active in either state, not a separate state.
- All stall/flush outputs and mdv_go are combinational from state and inputs. The counters, mdv_err, the done flag and the state are registered.
- reset high: next state RUN; stall_cnt, tmo_cnt, done_q and mdv_err all 0. Outputs during reset: flushD=flushE=1; all others 0.
- memwait = dmem_reqM & ~dmem_ready. Priority 1 in any state:
  - stallF=stallD=stallE=stallM=1, flushW=1, all other flushes 0, mdv_go=0.
  - State holds.
  - A mdv_done arriving during memwait sets done_q.
- RUN, no memwait, mdv_opE=1:
  - mdv_go=1 for that cycle; stallF=stallD=stallE=1, flushM=1.
  - Next state MDV_WAIT; tmo_cnt←0.
- RUN, pcsrcE=1: flushD=flushE=1, no stalls. This takes priority over load-use.
- RUN, load-use: lwst = resultsrcE0 & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
  - stallF=stallD=1, flushE=1.
  - Exactly one bubble, because the load leaves E next cycle.
- RUN, otherwise: all outputs 0.
- MDV_WAIT, no memwait:
  - done = mdv_done | done_q.
  - If done: all stalls/flushes 0, next RUN, done_q←0 (E advances this cycle).
  - Else if tmo_cnt==MDV_MAX-1: mdv_err←1 (sticky until reset), stalls released, flushE=1 to discard the op, next RUN.
  - Else: stallF=stallD=stallE=1, flushM=1, tmo_cnt+1. mdv_go stays 0 (no re-issue).
- pcsrcE and load-use are ignored in MDV_WAIT, since E holds the mul/div op.
- stall_cnt increments whenever stallF=1 and reset=0. It wraps modulo 2^CNT_W.
- busy = (state==MDV_WAIT).

Test Plan:
- Load-use: resultsrcE0=1, RdE=5, Rs2D=5 for 1 cycle → stallF=stallD=flushE=1 that cycle only; stall_cnt 0→1. Repeat with RdE=0 → no stall.
- Branch with load-use pattern: pcsrcE=1, resultsrcE0=0, Rs1D=RdE=3 → flushD=flushE=1, stallF=0.
- Mul/div: mdv_opE=1 in RUN → mdv_go pulse 1 cycle, busy=1. mdv_done on the 4th cycle after → stalls drop that cycle, busy=0 next; stall_cnt=4.
- Memwait inside MDV_WAIT: dmem_ready=0 for 3 cycles while mdv_done pulses → stallM=flushW=1 for those 3 cycles. On the first ready cycle, release via done_q, state RUN.
- Timeout: MDV_MAX=8, no mdv_done → after 8 MDV cycles mdv_err=1, flushE=1, state RUN. mdv_err stays 1 until reset.
- Reset mid-MDV_WAIT: assert reset → next cycle state RUN, busy=0, stall_cnt=0, mdv_err=0. During reset flushD=flushE=1.
